// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush/redirect controller.
// Pause bit indices, controller states, watchdog limit and address width.
package pipeline_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int PAUSE_W = 6;

  localparam int PAUSE_PC  = 0;
  localparam int PAUSE_IF  = 1;
  localparam int PAUSE_ID  = 2;
  localparam int PAUSE_EX  = 3;
  localparam int PAUSE_MEM = 4;
  localparam int PAUSE_WB  = 5;

  localparam int WDOG_W = 10;
  localparam logic [WDOG_W-1:0] WATCHDOG_LIMIT = 10'd1023;

  typedef enum logic [0:0] {
    CTRL_IDLE     = 1'b0,
    CTRL_REDIRECT = 1'b1
  } ctrl_state_e;

  // Contiguous stall mask covering stages 0..k.
  function automatic logic [PAUSE_W-1:0] pause_upto(input int k);
    logic [PAUSE_W-1:0] m;
    m = '0;
    for (int i = 0; i < PAUSE_W; i++)
      if (i <= k) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_watchdog.sv
// Stall watchdog: saturating count of consecutive paused cycles.
// Sets a sticky error once the count reaches WATCHDOG_LIMIT.
module pause_watchdog
  import pipeline_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic err
);

  logic [WDOG_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (!active)
        cnt <= '0;
      else if (cnt != WATCHDOG_LIMIT)
        cnt <= cnt + 1'b1;
      if (active && cnt == WATCHDOG_LIMIT - 1'b1)
        err <= 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: stall vector, flushes and PC redirect.
// Optional stall watchdog compiled in with PAUSE_WATCHDOG_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_req_if,
  input  logic              stall_req_id,
  input  logic              stall_req_ex,
  input  logic              stall_req_mem,
  input  logic              branch_flush,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              except_valid,
  input  logic [ADDR_W-1:0] except_target,
  input  logic              pc_ready,
  output logic [PAUSE_W-1:0] pause,
  output logic              flush_front,
  output logic              flush_all,
  output logic              new_pc_valid,
  output logic [ADDR_W-1:0] new_pc,
  output logic              watchdog_err
);

  ctrl_state_e       state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              exc_acc;
  logic              br_acc;

  always_comb begin
    pause = '0;
    priority case (1'b1)
      stall_req_mem: pause = pause_upto(PAUSE_MEM);
      stall_req_ex:  pause = pause_upto(PAUSE_EX);
      stall_req_id:  pause = pause_upto(PAUSE_ID);
      stall_req_if:  pause = pause_upto(PAUSE_IF);
      default:       pause = '0;
    endcase
    if (state == CTRL_REDIRECT)
      pause[PAUSE_PC] = 1'b1;
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = new_pc;
    flush_front = 1'b0;
    flush_all   = 1'b0;
    exc_acc     = except_valid && !stall_req_mem;
    br_acc      = 1'b0;
    if (exc_acc) begin
      flush_all = 1'b1;
      pc_nxt    = except_target;
      state_nxt = CTRL_REDIRECT;
    end else begin
      unique case (state)
        CTRL_IDLE: begin
          br_acc = branch_flush && !pause[PAUSE_EX];
          if (br_acc) begin
            flush_front = 1'b1;
            pc_nxt      = branch_target;
            state_nxt   = CTRL_REDIRECT;
          end
        end
        CTRL_REDIRECT: begin
          if (pc_ready)
            state_nxt = CTRL_IDLE;
        end
        default: state_nxt = CTRL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= CTRL_IDLE;
      new_pc <= '0;
    end else begin
      state  <= state_nxt;
      new_pc <= pc_nxt;
    end
  end

  assign new_pc_valid = (state == CTRL_REDIRECT);

`ifdef PAUSE_WATCHDOG_EN
  pause_watchdog u_wdog (
    .clk    (clk),
    .rst    (rst),
    .active (|pause),
    .err    (watchdog_err)
  );
`else
  assign watchdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: stall table plus redirect,
// exception, pending-exception, reset and watchdog sequences.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
  logic        branch_flush;
  logic [31:0] branch_target;
  logic        except_valid;
  logic [31:0] except_target;
  logic        pc_ready;
  logic [5:0]  pause;
  logic        flush_front, flush_all, new_pc_valid, watchdog_err;
  logic [31:0] new_pc;

  pipeline_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stall_req_if  (stall_req_if),
    .stall_req_id  (stall_req_id),
    .stall_req_ex  (stall_req_ex),
    .stall_req_mem (stall_req_mem),
    .branch_flush  (branch_flush),
    .branch_target (branch_target),
    .except_valid  (except_valid),
    .except_target (except_target),
    .pc_ready      (pc_ready),
    .pause         (pause),
    .flush_front   (flush_front),
    .flush_all     (flush_all),
    .new_pc_valid  (new_pc_valid),
    .new_pc        (new_pc),
    .watchdog_err  (watchdog_err)
  );

  always #5 clk = ~clk;

  typedef enum int {S_PAUSE, S_FF, S_FA, S_NPV, S_NPC, S_WD} sel_e;

  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic [5:0] exp_pause;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [31:0] observe(sel_e s);
    case (s)
      S_PAUSE: return {26'd0, pause};
      S_FF:    return {31'd0, flush_front};
      S_FA:    return {31'd0, flush_all};
      S_NPV:   return {31'd0, new_pc_valid};
      S_NPC:   return new_pc;
      default: return {31'd0, watchdog_err};
    endcase
  endfunction

  task automatic expect_v(string name, sel_e s, logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel  = s;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] a;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = observe(e.sel);
      n_vec++;
      if (a !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h want %h", e.name, a, e.val);
      end
    end
  endtask

  // Check at negedge, then move to just after the next posedge.
  task automatic tick();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {stall_req_if, stall_req_id, stall_req_ex, stall_req_mem} = 4'b0;
    branch_flush  = 1'b0;
    branch_target = '0;
    except_valid  = 1'b0;
    except_target = '0;
    pc_ready      = 1'b0;
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{4'b0000, 6'b000000};
    tbl[1] = '{4'b1000, 6'b000011};
    tbl[2] = '{4'b0100, 6'b000111};
    tbl[3] = '{4'b0010, 6'b001111};
    tbl[4] = '{4'b0110, 6'b001111};
    tbl[5] = '{4'b0000, 6'b000000};
    tbl[6] = '{4'b0001, 6'b011111};
    tbl[7] = '{4'b1111, 6'b011111};
    tbl[8] = '{4'b1010, 6'b001111};
    tbl[9] = '{4'b0000, 6'b000000};

    idle_inputs();
    rst = 1'b0;
    stall_req_ex = 1'b1;
    #2;
    expect_v("rst_npv", S_NPV, 32'd0);
    expect_v("rst_npc", S_NPC, 32'd0);
    expect_v("rst_ff", S_FF, 32'd0);
    expect_v("rst_fa", S_FA, 32'd0);
    expect_v("rst_wd", S_WD, 32'd0);
    expect_v("rst_pause", S_PAUSE, 32'h0F);
    tick();
    stall_req_ex = 1'b0;
    rst = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      {stall_req_if, stall_req_id, stall_req_ex, stall_req_mem} = tbl[i].req;
      expect_v($sformatf("tbl%0d_pause", i), S_PAUSE, {26'd0, tbl[i].exp_pause});
      expect_v($sformatf("tbl%0d_ff", i), S_FF, 32'd0);
      tick();
    end

    // Branch redirect
    branch_flush  = 1'b1;
    branch_target = 32'h1C00_0040;
    expect_v("br_ff", S_FF, 32'd1);
    expect_v("br_fa", S_FA, 32'd0);
    expect_v("br_npv0", S_NPV, 32'd0);
    tick();
    branch_flush = 1'b0;
    expect_v("br_npv1", S_NPV, 32'd1);
    expect_v("br_npc", S_NPC, 32'h1C00_0040);
    expect_v("br_pause", S_PAUSE, 32'h01);
    expect_v("br_ff2", S_FF, 32'd0);
    tick();
    pc_ready = 1'b1;
    expect_v("br_npv3", S_NPV, 32'd1);
    tick();
    pc_ready = 1'b0;
    expect_v("br_npv4", S_NPV, 32'd0);
    expect_v("br_pause4", S_PAUSE, 32'h00);
    tick();

    // Branch blocked while EX stalls
    branch_flush  = 1'b1;
    stall_req_ex  = 1'b1;
    branch_target = 32'h0000_1234;
    expect_v("brst_ff", S_FF, 32'd0);
    tick();
    idle_inputs();
    expect_v("brst_npv", S_NPV, 32'd0);
    tick();

    // Exception beats branch
    except_valid  = 1'b1;
    except_target = 32'h1C00_8000;
    branch_flush  = 1'b1;
    branch_target = 32'hDEAD_0000;
    expect_v("exb_fa", S_FA, 32'd1);
    expect_v("exb_ff", S_FF, 32'd0);
    tick();
    idle_inputs();
    expect_v("exb_npc", S_NPC, 32'h1C00_8000);
    expect_v("exb_npv", S_NPV, 32'd1);
    tick();

    // Branch ignored in REDIRECT
    branch_flush  = 1'b1;
    branch_target = 32'h0BAD_0BAD;
    expect_v("rdb_ff", S_FF, 32'd0);
    tick();
    branch_flush = 1'b0;
    expect_v("rdb_npc", S_NPC, 32'h1C00_8000);
    expect_v("rdb_npv", S_NPV, 32'd1);
    tick();

    // Exception overwrites in REDIRECT
    except_valid  = 1'b1;
    except_target = 32'h1C00_9000;
    expect_v("rde_fa", S_FA, 32'd1);
    tick();
    except_valid = 1'b0;
    expect_v("rde_npc", S_NPC, 32'h1C00_9000);
    expect_v("rde_npv", S_NPV, 32'd1);
    @(negedge clk);
    drain();

    // Reset mid-REDIRECT
    rst = 1'b0;
    #1;
    expect_v("rdr_npv", S_NPV, 32'd0);
    expect_v("rdr_npc", S_NPC, 32'd0);
    drain();
    @(posedge clk);
    #1;
    rst = 1'b1;
    expect_v("rdr_npv2", S_NPV, 32'd0);
    tick();

    // Exception held off by MEM stall
    except_valid  = 1'b1;
    except_target = 32'h1C00_A000;
    stall_req_mem = 1'b1;
    for (int c = 0; c < 3; c++) begin
      expect_v($sformatf("exm%0d_fa", c), S_FA, 32'd0);
      expect_v($sformatf("exm%0d_pause", c), S_PAUSE, 32'h1F);
      tick();
    end
    stall_req_mem = 1'b0;
    expect_v("exm_fa", S_FA, 32'd1);
    expect_v("exm_pause", S_PAUSE, 32'h00);
    tick();
    except_valid = 1'b0;
    pc_ready     = 1'b1;
    expect_v("exm_npc", S_NPC, 32'h1C00_A000);
    expect_v("exm_npv", S_NPV, 32'd1);
    tick();
    pc_ready = 1'b0;
    expect_v("exm_npv2", S_NPV, 32'd0);
    tick();

`ifdef PAUSE_WATCHDOG_EN
    stall_req_if = 1'b1;
    for (int c = 1; c <= 1023; c++) begin
      if (c == 1022) expect_v("wd_1022", S_WD, 32'd0);
      if (c == 1023) expect_v("wd_1023", S_WD, 32'd1);
      @(posedge clk);
      @(negedge clk);
      drain();
    end
    @(posedge clk);
    #1;
    stall_req_if = 1'b0;
    expect_v("wd_hold", S_WD, 32'd1);
    tick();
    expect_v("wd_hold2", S_WD, 32'd1);
    tick();
`else
    stall_req_if = 1'b1;
    repeat (20) tick();
    expect_v("wd_off", S_WD, 32'd0);
    tick();
    stall_req_if = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
